// File: rtl/ids_bus_matrix.sv
// ids_bus_matrix: multi-master / multi-slave shared bus with single-owner arbitration,
// address-nibble slave decode and a one-deep registered read-response path.
module ids_bus_matrix #(
    parameter int                 N_MST    = 3,
    parameter int                 N_SLV    = 4,
    parameter int                 DW       = 32,
    parameter int                 RR_MODE  = 0,
    parameter int                 HOLD_MAX = 0,
    parameter logic [4*N_SLV-1:0] SLV_SEL  = {4'h8, 4'h4, 4'h2, 4'h0}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_MST-1:0]      i_req,
    output logic [N_MST-1:0]      o_gnt,
    input  logic [N_MST*32-1:0]   i_m_addr,
    input  logic [N_MST*4-1:0]    i_m_size,
    input  logic [N_MST*DW-1:0]   i_m_din,
    input  logic [N_MST-1:0]      i_m_write,
    input  logic [N_MST-1:0]      i_m_read,
    output logic [DW-1:0]         o_m_dout,
    output logic [N_MST-1:0]      o_m_rvalid,
    output logic [N_MST-1:0]      o_m_err,
    output logic [N_SLV*32-1:0]   o_s_addr,
    output logic [N_SLV*4-1:0]    o_s_size,
    output logic [N_SLV*DW-1:0]   o_s_din,
    output logic [N_SLV-1:0]      o_s_write,
    output logic [N_SLV-1:0]      o_s_read,
    input  logic [N_SLV*DW-1:0]   i_s_dout
);

    localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   owner_q, owner_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            rsp_vld_q;
    logic            rsp_err_q;
    logic [MW-1:0]   rsp_owner_q;
    logic [SW-1:0]   rsp_slave_q;

    logic [N_MST-1:0] owner_oh;
    logic [N_MST-1:0] rsp_oh;
    logic [N_MST-1:0] others;

    logic [31:0]      m_addr [N_MST];
    logic [3:0]       m_size [N_MST];
    logic [DW-1:0]    m_din  [N_MST];
    logic [DW-1:0]    s_dout [N_SLV];

    logic [31:0]      g_addr;
    logic [3:0]       g_size;
    logic [DW-1:0]    g_din;
    logic             g_wr;
    logic             g_rd;

    logic [N_SLV-1:0] slv_hit;
    logic [N_SLV-1:0] slv_sel;
    logic [SW-1:0]    slv_idx;
    logic             mapped;

    genvar gi;

    generate
        for (gi = 0; gi < N_MST; gi++) begin : g_mst
            assign m_addr[gi]   = i_m_addr[gi*32 +: 32];
            assign m_size[gi]   = i_m_size[gi*4 +: 4];
            assign m_din[gi]    = i_m_din[gi*DW +: DW];
            assign owner_oh[gi] = (owner_q == MW'(gi));
            assign rsp_oh[gi]   = (rsp_owner_q == MW'(gi));
        end
    endgenerate

    // Winner among reqs; round-robin searches upward from the slot after last.
    function automatic logic [MW-1:0] pick(input logic [N_MST-1:0] reqs,
                                           input logic [MW-1:0]    last);
        logic [MW-1:0] win;
        int            idx;
        win = '0;
        if (RR_MODE != 0) begin
            for (int k = N_MST; k >= 1; k--) begin
                idx = (int'(last) + k) % N_MST;
                if (reqs[idx]) win = MW'(idx);
            end
        end else begin
            for (int k = N_MST - 1; k >= 0; k--) begin
                if (reqs[k]) win = MW'(k);
            end
        end
        return win;
    endfunction

    assign others = i_req & ~owner_oh;
    assign o_gnt  = (state_q == ST_OWNED) ? owner_oh : '0;

    // owner_q keeps the last owner through IDLE, so it doubles as the round-robin pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d = ST_OWNED;
                    owner_d = pick(i_req, owner_q);
                    hold_d  = '0;
                end
            end
            ST_OWNED: begin
                if (!i_req[owner_q]) begin
                    hold_d = '0;
                    if (|others) begin
                        owner_d = pick(others, owner_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if ((HOLD_MAX > 0) && (|others)) begin
                    if (int'(hold_q) + 1 >= HOLD_MAX) begin
                        owner_d = pick(others, owner_q);
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= MW'(N_MST - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    // Only the current owner's transfer fields are forwarded; a write masks a read.
    always_comb begin
        g_addr = '0;
        g_size = '0;
        g_din  = '0;
        g_wr   = 1'b0;
        g_rd   = 1'b0;
        if (state_q == ST_OWNED) begin
            g_addr = m_addr[owner_q];
            g_size = m_size[owner_q];
            g_din  = m_din[owner_q];
            g_wr   = i_m_write[owner_q];
            g_rd   = i_m_read[owner_q] & ~i_m_write[owner_q];
        end
    end

    always_comb begin
        slv_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (slv_hit[k]) slv_idx = SW'(k);
        end
    end

    assign mapped = |slv_hit;

    generate
        for (gi = 0; gi < N_SLV; gi++) begin : g_slv
            assign slv_hit[gi]            = (g_addr[31:28] == SLV_SEL[gi*4 +: 4]);
            assign slv_sel[gi]            = slv_hit[gi] && (slv_idx == SW'(gi));
            assign s_dout[gi]             = i_s_dout[gi*DW +: DW];
            assign o_s_addr[gi*32 +: 32]  = slv_sel[gi] ? g_addr : '0;
            assign o_s_size[gi*4 +: 4]    = slv_sel[gi] ? g_size : '0;
            assign o_s_din[gi*DW +: DW]   = slv_sel[gi] ? g_din  : '0;
            assign o_s_write[gi]          = slv_sel[gi] & g_wr;
            assign o_s_read[gi]           = slv_sel[gi] & g_rd;
        end
    endgenerate

    // Response side latches owner/slave so a grant change next cycle cannot misroute it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_owner_q <= '0;
            rsp_slave_q <= '0;
        end else begin
            rsp_vld_q   <= g_rd;
            rsp_err_q   <= (g_rd | g_wr) & ~mapped;
            rsp_owner_q <= owner_q;
            rsp_slave_q <= slv_idx;
        end
    end

    assign o_m_rvalid = rsp_vld_q ? rsp_oh : '0;
    assign o_m_err    = rsp_err_q ? rsp_oh : '0;
    assign o_m_dout   = (rsp_vld_q && !rsp_err_q) ? s_dout[rsp_slave_q] : '0;

endmodule

// File: tb/tb_ids_bus_matrix.sv
// Bench for ids_bus_matrix: three parameterisations share one stimulus bus; grant and
// read-response monitors pop expectations pushed by the directed stimulus.
module tb_ids_bus_matrix;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [95:0]  m_addr;
    logic [11:0]  m_size;
    logic [95:0]  m_din;
    logic [2:0]   m_write;
    logic [2:0]   m_read;
    logic [127:0] s_dout;

    logic [2:0]   f_gnt, r_gnt, h_gnt;
    logic [31:0]  f_dout, r_dout, h_dout;
    logic [2:0]   f_rvalid, r_rvalid, h_rvalid;
    logic [2:0]   f_err, r_err, h_err;
    logic [127:0] f_s_addr, r_s_addr, h_s_addr;
    logic [15:0]  f_s_size, r_s_size, h_s_size;
    logic [127:0] f_s_din, r_s_din, h_s_din;
    logic [3:0]   f_s_write, r_s_write, h_s_write;
    logic [3:0]   f_s_read, r_s_read, h_s_read;

    int n_chk  = 0;
    int n_fail = 0;
    int gnt_sel = 0;

    typedef struct packed {
        logic [2:0]  rv;
        logic [2:0]  er;
        logic [31:0] d;
    } rsp_t;

    rsp_t       exp_rsp_q[$];
    logic [2:0] exp_gnt_q[$];

    // Nibble 4 appears for slaves 1 and 3: slave 1 must win; nibble 8 is unmapped here.
    ids_bus_matrix #(.RR_MODE(0), .HOLD_MAX(0), .SLV_SEL(16'h4240)) u_fix (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(f_gnt),
        .i_m_addr(m_addr), .i_m_size(m_size), .i_m_din(m_din),
        .i_m_write(m_write), .i_m_read(m_read),
        .o_m_dout(f_dout), .o_m_rvalid(f_rvalid), .o_m_err(f_err),
        .o_s_addr(f_s_addr), .o_s_size(f_s_size), .o_s_din(f_s_din),
        .o_s_write(f_s_write), .o_s_read(f_s_read), .i_s_dout(s_dout)
    );

    ids_bus_matrix #(.RR_MODE(1), .HOLD_MAX(0)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(r_gnt),
        .i_m_addr(m_addr), .i_m_size(m_size), .i_m_din(m_din),
        .i_m_write(m_write), .i_m_read(m_read),
        .o_m_dout(r_dout), .o_m_rvalid(r_rvalid), .o_m_err(r_err),
        .o_s_addr(r_s_addr), .o_s_size(r_s_size), .o_s_din(r_s_din),
        .o_s_write(r_s_write), .o_s_read(r_s_read), .i_s_dout(s_dout)
    );

    ids_bus_matrix #(.RR_MODE(0), .HOLD_MAX(4)) u_hold (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(h_gnt),
        .i_m_addr(m_addr), .i_m_size(m_size), .i_m_din(m_din),
        .i_m_write(m_write), .i_m_read(m_read),
        .o_m_dout(h_dout), .o_m_rvalid(h_rvalid), .o_m_err(h_err),
        .o_s_addr(h_s_addr), .o_s_size(h_s_size), .o_s_din(h_s_din),
        .o_s_write(h_s_write), .o_s_read(h_s_read), .i_s_dout(s_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave k answers a read with 0xCAFE_000k next cycle; otherwise shows a poison value.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            s_dout[k*32 +: 32] <= f_s_read[k] ? (32'hCAFE_0000 | 32'(k)) : (32'hBAD0_0000 | 32'(k));
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic wr, input logic rd);
        m_addr[m*32 +: 32] = a;
        m_din[m*32 +: 32]  = d;
        m_size[m*4 +: 4]   = 4'h2;
        m_write[m]         = wr;
        m_read[m]          = rd;
    endtask

    task automatic clear_m();
        m_addr  = '0;
        m_din   = '0;
        m_size  = '0;
        m_write = '0;
        m_read  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        clear_m();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_rsp(input logic [2:0] rv, input logic [2:0] er, input logic [31:0] d);
        rsp_t e;
        e.rv = rv;
        e.er = er;
        e.d  = d;
        exp_rsp_q.push_back(e);
    endtask

    // Grant monitor: every cycle the selected instance grants, pop one expected grant.
    always @(negedge clk) begin
        logic [2:0] g;
        g = '0;
        case (gnt_sel)
            1: g = f_gnt;
            2: g = r_gnt;
            3: g = h_gnt;
            default: g = '0;
        endcase
        if (g != 3'b000) begin
            if (exp_gnt_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL gnt_unexpected: got %b, required none", g);
            end else begin
                logic [2:0] eg;
                eg = exp_gnt_q.pop_front();
                $display("gnt dut=%0d got=%b exp=%b", gnt_sel, g, eg);
                chk("gnt", 128'(g), 128'(eg));
            end
        end
    end

    // Response monitor: pops whenever the fixed-mode instance presents rvalid or err.
    always @(negedge clk) begin
        if (f_rvalid != 3'b000 || f_err != 3'b000) begin
            if (exp_rsp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rvalid=%b err=%b dout=%h, required none",
                         f_rvalid, f_err, f_dout);
            end else begin
                rsp_t e;
                e = exp_rsp_q.pop_front();
                $display("rsp rvalid=%b err=%b dout=%h (exp %b %b %h)",
                         f_rvalid, f_err, f_dout, e.rv, e.er, e.d);
                chk("rsp_rvalid", 128'(f_rvalid), 128'(e.rv));
                chk("rsp_err", 128'(f_err), 128'(e.er));
                chk("rsp_dout", 128'(f_dout), 128'(e.d));
            end
        end else begin
            chk("dout_idle_zero", 128'(f_dout), 128'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        clear_m();
        tick();
        tick();
        chk("rst_gnt_fix", 128'(f_gnt), 128'(0));
        chk("rst_gnt_rr", 128'(r_gnt), 128'(0));
        chk("rst_gnt_hold", 128'(h_gnt), 128'(0));
        chk("rst_rvalid", 128'(f_rvalid), 128'(0));
        chk("rst_err", 128'(f_err), 128'(0));
        chk("rst_strobes", 128'({f_s_read, f_s_write}), 128'(0));
        rst_n = 1'b1;

        // Fixed priority: owner 1 keeps the bus while master 0 waits.
        gnt_sel = 1;
        req = 3'b110; exp_gnt_q.push_back(3'b010); tick();
        req = 3'b111; exp_gnt_q.push_back(3'b010); tick();
        exp_gnt_q.push_back(3'b010); tick();
        req = 3'b101; exp_gnt_q.push_back(3'b001); tick();
        req = 3'b000; tick(); tick();
        chk("gnt_q_fixed_drained", 128'(exp_gnt_q.size()), 128'(0));

        // Round-robin: each master drops after one granted cycle, then re-requests.
        gnt_sel = 0;
        do_reset();
        gnt_sel = 2;
        req = 3'b111; exp_gnt_q.push_back(3'b001); tick();
        req = 3'b110; exp_gnt_q.push_back(3'b010); tick();
        req = 3'b101; exp_gnt_q.push_back(3'b100); tick();
        req = 3'b011; exp_gnt_q.push_back(3'b001); tick();
        req = 3'b000; tick(); tick();
        chk("gnt_q_rr_drained", 128'(exp_gnt_q.size()), 128'(0));

        // Hold limit 4: ownership alternates every four cycles while both request.
        gnt_sel = 0;
        do_reset();
        gnt_sel = 3;
        req = 3'b101;
        repeat (4) exp_gnt_q.push_back(3'b001);
        repeat (4) exp_gnt_q.push_back(3'b100);
        exp_gnt_q.push_back(3'b001);
        repeat (9) tick();
        req = 3'b000; tick(); tick();
        chk("gnt_q_hold_drained", 128'(exp_gnt_q.size()), 128'(0));

        // Data path on the fixed-mode instance.
        gnt_sel = 0;
        do_reset();
        req = 3'b010; tick();
        set_m(1, 32'h4000_0010, 32'h0, 1'b0, 1'b1);
        push_rsp(3'b010, 3'b000, 32'hCAFE_0001);
        #1;
        chk("rd1_s_read", 128'(f_s_read), 128'(4'b0010));
        chk("rd1_s_addr", 128'(f_s_addr[32 +: 32]), 128'(32'h4000_0010));
        chk("rd1_s_size", 128'(f_s_size[4 +: 4]), 128'(4'h2));
        chk("rd1_s_write", 128'(f_s_write), 128'(0));
        tick();
        set_m(1, 32'h2000_0000, 32'h0, 1'b0, 1'b1);
        push_rsp(3'b010, 3'b000, 32'hCAFE_0002);
        #1;
        chk("rd2_s_read", 128'(f_s_read), 128'(4'b0100));
        tick();
        set_m(1, 32'h0000_0004, 32'h1234_5678, 1'b1, 1'b1);
        #1;
        chk("wr_s_write", 128'(f_s_write), 128'(4'b0001));
        chk("wr_s_read_masked", 128'(f_s_read), 128'(0));
        chk("wr_s_din", 128'(f_s_din[31:0]), 128'(32'h1234_5678));
        tick();
        set_m(1, 32'hF000_0000, 32'h0, 1'b0, 1'b1);
        push_rsp(3'b010, 3'b010, 32'h0);
        #1;
        chk("unm_rd_strobes", 128'({f_s_read, f_s_write}), 128'(0));
        tick();
        set_m(1, 32'hF000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        push_rsp(3'b000, 3'b010, 32'h0);
        #1;
        chk("unm_wr_strobes", 128'(f_s_write), 128'(0));
        tick();
        clear_m();
        req = 3'b001; tick();
        chk("gnt_switch_m0", 128'(f_gnt), 128'(3'b001));
        set_m(0, 32'hF000_0000, 32'h0, 1'b0, 1'b1);
        set_m(1, 32'h4000_0000, 32'h0, 1'b0, 1'b1);
        push_rsp(3'b001, 3'b001, 32'h0);
        #1;
        chk("nonowner_gated_read", 128'(f_s_read), 128'(0));
        chk("nonowner_gated_addr", f_s_addr, 128'(0));
        tick();
        clear_m(); tick();

        // Reset asserted the cycle after a read strobe discards the response.
        set_m(0, 32'h0000_0000, 32'h0, 1'b0, 1'b1);
        #1;
        chk("rd3_s_read", 128'(f_s_read), 128'(4'b0001));
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid", 128'(f_rvalid), 128'(0));
        chk("rstmid_err", 128'(f_err), 128'(0));
        chk("rstmid_dout", 128'(f_dout), 128'(0));
        chk("rstmid_gnt", 128'(f_gnt), 128'(0));
        chk("rstmid_strobes", 128'({f_s_read, f_s_write}), 128'(0));
        clear_m();
        req = '0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rsp_q_drained", 128'(exp_rsp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ids_bus_matrix.md
IDS_BUS_MATRIX -- requirements
Module: ids_bus_matrix

Interface
REQ-001 SHALL have parameter N_MST, default 3, number of bus masters (1..8).
REQ-002 SHALL have parameter N_SLV, default 4, number of slaves (1..8).
REQ-003 SHALL have parameter DW, default 32, data width; address width fixed at 32, size field fixed at 4.
REQ-004 SHALL have parameter RR_MODE, default 0: 0 = fixed priority (master 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter HOLD_MAX, default 0, max consecutive granted cycles per owner when others request (0 = unlimited).
REQ-006 SHALL have parameter SLV_SEL, default {4'h8,4'h4,4'h2,4'h0}, one addr[31:28] nibble per slave, slave k at bits [4k+3:4k].
REQ-007 i_clk  in  1  clock; reset i_rst_n, asynchronous, active-low.
REQ-008 i_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_req  in  N_MST  per-master bus request.
REQ-010 o_gnt  out  N_MST  registered one-hot grant.
REQ-011 i_m_addr / i_m_size / i_m_din  in  N_MST*32 / N_MST*4 / N_MST*DW  packed per-master, master m at slice m.
REQ-012 i_m_write / i_m_read  in  N_MST each  per-master strobes.
REQ-013 o_m_dout  out  DW  shared read data, qualified by o_m_rvalid.
REQ-014 o_m_rvalid / o_m_err  out  N_MST each  per-master read-valid and decode-error pulses.
REQ-015 o_s_addr / o_s_size / o_s_din  out  N_SLV*32 / N_SLV*4 / N_SLV*DW  packed per-slave.
REQ-016 o_s_write / o_s_read  out  N_SLV each  per-slave strobes.
REQ-017 i_s_dout  in  N_SLV*DW  per-slave read data, valid one cycle after read strobe.

Function
REQ-018 SHALL implement FSM IDLE/OWNED with owner index register and grant-hold counter.
REQ-019 IDLE: any i_req high -> OWNED, owner = arbitration winner, o_gnt[owner]=1 from next cycle.
REQ-020 OWNED with i_req[owner] low: if other requests pending, switch owner directly (no idle bubble); else -> IDLE, o_gnt=0.
REQ-021 Fixed mode: winner = lowest-index requester; round-robin: first requester searching upward from last owner+1, wrapping at N_MST-1 -> 0.
REQ-022 HOLD_MAX>0: hold counter increments each OWNED cycle with another master requesting; reaching HOLD_MAX forces re-arbitration excluding current owner; counter clears on owner change.
REQ-023 Master transfer fields SHALL reach slaves only when o_gnt[m]=1 in that cycle; routing combinational from owner register.
REQ-024 Decode: slave k selected when i_m_addr[31:28]==SLV_SEL nibble k; lowest k wins on duplicate nibbles; non-selected slave outputs all zero.
REQ-025 Unmapped address: no slave strobe; write dropped; o_m_err[owner] pulses next cycle; read also pulses o_m_rvalid[owner] with o_m_dout=0.
REQ-026 Mapped read at cycle t: register {owner, slave, valid}; at t+1 o_m_rvalid[owner]=1 for one cycle, o_m_dout = i_s_dout[slave]; back-to-back reads pipeline at 1/cycle.
REQ-027 Response routing SHALL use the registered owner/slave, unaffected by grant change at t+1.
REQ-028 o_m_dout SHALL be 0 when no o_m_rvalid bit high; writes produce no rvalid.
REQ-029 Simultaneous read and write strobes: write takes precedence, read ignored.

Reset
REQ-030 Reset SHALL force IDLE, o_gnt=0, all slave strobes 0, o_m_rvalid=0, o_m_err=0, o_m_dout=0, hold counter 0, round-robin pointer N_MST-1 (master 0 wins first).
REQ-031 Reset mid-read SHALL discard the pending response; no rvalid after release.

Verification
REQ-032 Fixed mode, i_req=3'b110 then 3'b111 -> grant master 1, holds while i_req[1] high despite master 0 request; on drop, master 0 granted next cycle.
REQ-033 RR_MODE=1, all three request continuously, each drops req after one transfer -> grant order 0,1,2,0.
REQ-034 HOLD_MAX=4, master 0 holds req, master 2 requests -> master 0 granted 4 cycles, then master 2 granted.
REQ-035 Master 1 reads 0x4000_0010, slave 1 returns 0xCAFE_0001 -> o_m_rvalid=3'b010, o_m_dout=0xCAFE_0001 one cycle after strobe.
REQ-036 Master 0 reads 0xF000_0000 -> no slave strobe, next cycle o_m_rvalid[0]=1, o_m_err[0]=1, o_m_dout=0.
REQ-037 Assert i_rst_n low cycle after read strobe -> all outputs 0 immediately, no rvalid after release.
